// File: rtl/i2c_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_arbiter
// Purpose : Round-robin arbiter and sequencer that shares one I2cMain controller
//           between two requesters. It grants one requester, latches its
//           command, strobes I2cMain, watches SCL/SDA for the closing STOP and
//           returns a DONE (with read data) or a timeout ERR pulse.
// Ports   :
//   i_clk, i_rst                     clock, async active-high reset
//   i_req0/1, i_rnw0/1               request level and direction (1 = read)
//   i_addr0/1 [6:0], i_wdata0/1      request address and write data
//   o_gnt0/1                         grant, grant cycle through DONE/ERR cycle
//   o_done0/1, o_err0/1              one-cycle completion / timeout pulses
//   o_rdata0/1 [15:0]                last read data per requester
//   o_start_stb, o_rnw, o_i2c_addr,
//   o_wr_data                        command interface to I2cMain
//   i_scl, i_sda_out, i_sda_oe       bus activity monitored from I2cMain
//   i_rd_data [15:0]                 read data from I2cMain
// -----------------------------------------------------------------------------
module i2c_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_rnw0,
    input  logic        i_rnw1,
    input  logic [6:0]  i_addr0,
    input  logic [6:0]  i_addr1,
    input  logic [15:0] i_wdata0,
    input  logic [15:0] i_wdata1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_done0,
    output logic        o_done1,
    output logic        o_err0,
    output logic        o_err1,
    output logic [15:0] o_rdata0,
    output logic [15:0] o_rdata1,
    output logic        o_start_stb,
    output logic        o_rnw,
    output logic [6:0]  o_i2c_addr,
    output logic [15:0] o_wr_data,
    input  logic        i_scl,
    input  logic        i_sda_out,
    input  logic        i_sda_oe,
    input  logic [15:0] i_rd_data
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_STOP,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    logic               r_ptr;
    logic               r_win;
    logic               r_sda_prev;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_win;
    logic               w_stop;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_timeout;

    // Winner: the only requester, or the pointer's choice on a tie
    assign w_win     = (i_req0 && i_req1) ? r_ptr : i_req1;

    // STOP: SDA driven high while SCL is high, after being low last cycle
    assign w_stop    = i_scl && i_sda_oe && i_sda_out && !r_sda_prev;

    // Abort when the count reaches TIMEOUT-1; the counter never wraps
    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sequencer; handshake outputs are registered alongside the state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_win       <= 1'b0;
            r_sda_prev  <= 1'b0;
            r_cnt       <= '0;
            o_gnt0      <= 1'b0;
            o_gnt1      <= 1'b0;
            o_done0     <= 1'b0;
            o_done1     <= 1'b0;
            o_err0      <= 1'b0;
            o_err1      <= 1'b0;
            o_rdata0    <= '0;
            o_rdata1    <= '0;
            o_start_stb <= 1'b0;
            o_rnw       <= 1'b0;
            o_i2c_addr  <= '0;
            o_wr_data   <= '0;
        end else begin
            r_sda_prev  <= i_sda_out;
            o_start_stb <= 1'b0;
            o_done0     <= 1'b0;
            o_done1     <= 1'b0;
            o_err0      <= 1'b0;
            o_err1      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_win       <= w_win;
                        o_rnw       <= w_win ? i_rnw1   : i_rnw0;
                        o_i2c_addr  <= w_win ? i_addr1  : i_addr0;
                        o_wr_data   <= w_win ? i_wdata1 : i_wdata0;
                        o_gnt0      <= !w_win;
                        o_gnt1      <= w_win;
                        o_start_stb <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_START;
                end

                S_WAIT_START: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_timeout) begin
                        o_err0  <= !r_win;
                        o_err1  <= r_win;
                        r_state <= S_ERR;
                    end else if (!i_scl) begin
                        r_state <= S_WAIT_STOP;
                    end
                end

                S_WAIT_STOP: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_timeout) begin
                        o_err0  <= !r_win;
                        o_err1  <= r_win;
                        r_state <= S_ERR;
                    end else if (w_stop) begin
                        o_done0 <= !r_win;
                        o_done1 <= r_win;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (o_rnw) begin
                        if (r_win) o_rdata1 <= i_rd_data;
                        else       o_rdata0 <= i_rd_data;
                    end
                    o_gnt0  <= 1'b0;
                    o_gnt1  <= 1'b0;
                    r_ptr   <= !r_win;
                    r_state <= S_IDLE;
                end

                S_ERR: begin
                    o_gnt0  <= 1'b0;
                    o_gnt1  <= 1'b0;
                    r_ptr   <= !r_win;
                    r_state <= S_IDLE;
                end

                default: begin
                    o_gnt0  <= 1'b0;
                    o_gnt1  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_arbiter
// Purpose : Directed bench for i2c_arbiter. Expected transactions are queued
//           when requests are driven and compared when the arbiter launches
//           and completes them; the I2C bus is stubbed by driving SCL/SDA.
// -----------------------------------------------------------------------------
module tb_i2c_arbiter;

    localparam int unsigned TO = 16;

    typedef struct {
        bit          idx;
        bit          err;
        logic        rnw;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rd_bus;
        logic [15:0] exp_rdata;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, rnw0, rnw1;
    logic [6:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic        start_stb, rnw;
    logic [6:0]  i2c_addr;
    logic [15:0] wr_data;
    logic        scl, sda_out, sda_oe;
    logic [15:0] rd_data;

    int checks   = 0;
    int failures = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    i2c_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_req1(req1), .i_rnw0(rnw0), .i_rnw1(rnw1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
        .o_err0(err0), .o_err1(err1), .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_start_stb(start_stb), .o_rnw(rnw), .o_i2c_addr(i2c_addr),
        .o_wr_data(wr_data),
        .i_scl(scl), .i_sda_out(sda_out), .i_sda_oe(sda_oe), .i_rd_data(rd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        scl = 1'b1; sda_out = 1'b1; sda_oe = 1'b0;
    endtask

    task automatic push(input bit idx, input logic r, input logic [6:0] a,
                        input logic [15:0] wd, input logic [15:0] rb,
                        input bit e, input logic [15:0] er);
        sb_t t;
        t.idx = idx; t.rnw = r; t.addr = a; t.wdata = wd;
        t.rd_bus = rb; t.err = e; t.exp_rdata = er;
        sb.push_back(t);
    endtask

    // Drive a request and queue the expected outcome
    task automatic req(input bit idx, input logic r, input logic [6:0] a,
                       input logic [15:0] wd, input logic [15:0] rb,
                       input bit e, input logic [15:0] er);
        if (idx) begin req1 = 1'b1; rnw1 = r; addr1 = a; wdata1 = wd; end
        else     begin req0 = 1'b1; rnw0 = r; addr0 = a; wdata0 = wd; end
        push(idx, r, a, wd, rb, e, er);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for launch, emulate the bus, compare against the queue head
    task automatic run_txn(input bit drive, input bit drop, input bit chg);
        sb_t e;
        int  n;
        int  c;
        bit  got;
        bit  fin;
        bit  other;
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        got = 1'b0;
        for (n = 1; n <= 20; n++) begin
            tick();
            if (start_stb) begin got = 1'b1; break; end
        end
        chk("start_seen", 32'(got), 32'd1);
        if (!got) return;
        chk("start_latency", 32'(n), 32'd1);
        chk("gnt_win",  32'(e.idx ? gnt1 : gnt0), 32'd1);
        chk("gnt_lose", 32'(e.idx ? gnt0 : gnt1), 32'd0);
        chk("cmd_rnw",  32'(rnw), 32'(e.rnw));
        chk("cmd_addr", 32'(i2c_addr), 32'(e.addr));
        chk("cmd_wdata", 32'(wr_data), 32'(e.wdata));
        rd_data = e.rd_bus;
        if (drive) begin scl = 1'b0; sda_out = 1'b0; sda_oe = 1'b1; end
        fin   = 1'b0;
        other = 1'b0;
        for (c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) chk("start_one_cycle", 32'(start_stb), 32'd0);
            other = other | (e.idx ? gnt0 : gnt1);
            if (done0 || done1 || err0 || err1) begin fin = 1'b1; break; end
            if (c == 2 && chg) wdata0 = 16'h0000;
            if (drive && c == 4) scl = 1'b1;
            if (drive && c == 5) sda_out = 1'b1;
        end
        chk("completion_seen", 32'(fin), 32'd1);
        if (!fin) begin bus_idle(); return; end
        chk("done0", 32'(done0), 32'(!e.err && !e.idx));
        chk("done1", 32'(done1), 32'(!e.err &&  e.idx));
        chk("err0",  32'(err0),  32'( e.err && !e.idx));
        chk("err1",  32'(err1),  32'( e.err &&  e.idx));
        if (e.err) chk("err_cycle_after_launch", 32'(c), 32'(TO));
        chk("gnt_at_end", 32'(e.idx ? gnt1 : gnt0), 32'd1);
        chk("wdata_held", 32'(wr_data), 32'(e.wdata));
        chk("other_gnt_quiet", 32'(other), 32'd0);
        if (drop) begin
            if (e.idx) req1 = 1'b0;
            else       req0 = 1'b0;
        end
        bus_idle();
        tick();
        chk("rdata", 32'(e.idx ? rdata1 : rdata0), 32'(e.exp_rdata));
        chk("pulse_once", 32'({done0, done1, err0, err1}), 32'd0);
        chk("gnt_released", 32'({gnt0, gnt1}), 32'd0);
    endtask

    initial begin
        int  n;
        bit  got;
        bit  any;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rnw0 = 1'b0; rnw1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rd_data = '0;
        bus_idle();
        tick();
        tick();
        chk("rst_ctrl", 32'({gnt0, gnt1, done0, done1, err0, err1, start_stb, rnw}), 32'd0);
        chk("rst_cmd", 32'({i2c_addr, wr_data}), 32'd0);
        chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        rst = 1'b0;
        tick();

        // Single write from requester 0
        req(1'b0, 1'b0, 7'h2A, 16'hBEEF, 16'h0000, 1'b0, 16'h0000);
        run_txn(1'b1, 1'b1, 1'b0);

        // Single read from requester 1
        req(1'b1, 1'b1, 7'h2A, 16'h0000, 16'h1234, 1'b0, 16'h1234);
        run_txn(1'b1, 1'b1, 1'b0);

        // Tie after reset: 0 first, then alternate while both are held
        do_reset();
        req(1'b0, 1'b0, 7'h10, 16'h1111, 16'h0000, 1'b0, 16'h0000);
        req(1'b1, 1'b0, 7'h11, 16'h2222, 16'h0000, 1'b0, 16'h0000);
        push(1'b0, 1'b0, 7'h10, 16'h1111, 16'h0000, 1'b0, 16'h0000);
        push(1'b1, 1'b0, 7'h11, 16'h2222, 16'h0000, 1'b0, 16'h0000);
        run_txn(1'b1, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0);

        // Read to give RDATA0 a known value
        req(1'b0, 1'b1, 7'h33, 16'h0000, 16'h5A5A, 1'b0, 16'h5A5A);
        run_txn(1'b1, 1'b1, 1'b0);

        // Timeout with SCL stuck high; RDATA0 must keep 5A5A
        req(1'b0, 1'b1, 7'h33, 16'h0000, 16'hFFFF, 1'b1, 16'h5A5A);
        run_txn(1'b0, 1'b1, 1'b0);

        // Next request is granted; write data changed after grant is ignored
        req(1'b0, 1'b0, 7'h2A, 16'hBEEF, 16'h0000, 1'b0, 16'h5A5A);
        run_txn(1'b1, 1'b1, 1'b1);

        // Reset during WAIT_STOP aborts with no completion pulse
        req0 = 1'b1; rnw0 = 1'b0; addr0 = 7'h44; wdata0 = 16'hCAFE;
        got = 1'b0;
        for (n = 0; n < 20; n++) begin
            tick();
            if (start_stb) begin got = 1'b1; break; end
        end
        chk("abort_start_seen", 32'(got), 32'd1);
        scl = 1'b0; sda_out = 1'b0; sda_oe = 1'b1;
        tick();
        tick();
        tick();
        chk("abort_gnt_before", 32'(gnt0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ctrl", 32'({gnt0, gnt1, done0, done1, err0, err1, start_stb, rnw}), 32'd0);
        chk("abort_cmd", 32'({i2c_addr, wr_data}), 32'd0);
        chk("abort_rdata", 32'({rdata0, rdata1}), 32'd0);
        req0 = 1'b0;
        bus_idle();
        tick();
        tick();
        rst = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            any = any | done0 | done1 | err0 | err1 | gnt0 | gnt1;
        end
        chk("abort_no_pulse", 32'(any), 32'd0);

        // REQ1 alone after reset
        req(1'b1, 1'b1, 7'h2A, 16'h0000, 16'h0F0F, 1'b0, 16'h0F0F);
        run_txn(1'b1, 1'b1, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Two-requester arbiter and sequencer for the I2cMain controller. It grants the single I2C main to one of two requesters in round-robin order and latches that requester's command. It then drives I2cMain's START_STB/RNW/I2C_ADDR/WR_DATA inputs and tracks bus activity on SCL/SDA_OUT/SDA_OE to detect transaction completion. It returns read data and a done or error pulse to the granted requester. It sits between the system requesters and I2cMain in the same hierarchy as the tester and I2C models.

## Interface
- TIMEOUT_CYCLES, 4096: CLK cycles allowed from launch to STOP detection before the transaction is aborted; minimum 16.
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- REQ0, REQ1  input  1  transaction request, level, held until DONEn or ERRn
- RNW0, RNW1  input  1  1 = read, 0 = write
- ADDR0, ADDR1  input  7  target secondary address
- WDATA0, WDATA1  input  16  write data
- GNT0, GNT1  output  1  high from grant cycle through DONE/ERR cycle inclusive
- DONE0, DONE1  output  1  one-cycle completion pulse
- ERR0, ERR1  output  1  one-cycle timeout pulse
- RDATA0, RDATA1  output  16  last read data per requester
- START_STB  output  1  to I2cMain, one-cycle start strobe
- RNW  output  1  to I2cMain, latched command
- I2C_ADDR  output  7  to I2cMain, latched command
- WR_DATA  output  16  to I2cMain, latched command
- SCL, SDA_OUT, SDA_OE  input  1 each  monitored from I2cMain
- RD_DATA  input  16  from I2cMain

## Operation
- States: IDLE, LAUNCH, WAIT_START, WAIT_STOP, DONE, ERR.
- IDLE: if either REQ is high, pick the winner and go to LAUNCH.
  - With one REQ high, that requester wins.
  - With both high, the requester selected by the priority pointer PTR wins.
  - On grant: latch RNW/ADDR/WDATA of the winner into the command registers and store the winner index.
- LAUNCH: START_STB=1 for exactly this cycle; clear the timeout counter; go to WAIT_START.
- WAIT_START: wait for SCL==0 (bus active), then go to WAIT_STOP.
- WAIT_STOP: detect STOP as SCL==1 && SDA_OE==1 && SDA_OUT==1 && previous-cycle SDA_OUT==0; then go to DONE.
- Timeout: the counter increments in WAIT_START and WAIT_STOP. When it reaches TIMEOUT_CYCLES-1, go to ERR; this takes priority over a same-cycle STOP.
- DONE: DONEn=1 for the granted requester. If the latched RNW=1, RDATAn<=RD_DATA on this edge; otherwise RDATAn is unchanged. Then go to IDLE.
- ERR: ERRn=1 for the granted requester; RDATAn is unchanged; go to IDLE.
- PTR toggles to the non-granted requester on leaving DONE or ERR. A requester holding REQ high after its DONE is served again only after the other requester, if the other is requesting.
- Command outputs (RNW/I2C_ADDR/WR_DATA) hold their latched values until the next grant. REQ and request-data changes after grant are ignored.
- GNTn/START_STB/DONEn/ERRn are decoded from the registered state and winner index and are glitch-free.

## Timing
- Reset values (async assert, sync use after deassert):
  - State: IDLE.
  - PTR: 0, so requester 0 wins the first tie.
  - All GNT/DONE/ERR/START_STB: 0.
  - RNW, I2C_ADDR, WR_DATA, RDATA0, RDATA1: 0.
  - Counter and previous-SDA register: 0.
- REQ first sampled high at edge k gives GNT and START_STB high in cycle k+1.
- Minimum turnaround from the DONE cycle back to a new START_STB is 2 cycles (IDLE, then LAUNCH).
- RESET during any state aborts immediately. No DONE/ERR is issued for the aborted transaction, and the I2cMain reset is the system's responsibility.
- The counter is $clog2(TIMEOUT_CYCLES) bits and saturates logically via the ERR transition; it never wraps.

## Test plan
- Single write: REQ0=1, RNW0=0, ADDR0=7'h2A, WDATA0=16'hBEEF.
  - START_STB pulses one cycle after REQ0; I2C_ADDR=2A, WR_DATA=BEEF.
  - After the I2cSecondary STOP, DONE0 pulses once; RDATA0 stays 0.
- Single read: REQ1=1, RNW1=1, ADDR1=7'h2A, secondary RDS_DATA=16'h1234.
  - DONE1 pulses and RDATA1=1234; GNT0 never rises.
- Tie: REQ0 and REQ1 rise on the same edge after reset.
  - Requester 0 is served first, then requester 1.
  - With both held high, grants alternate 0,1,0,1.
- Timeout: TIMEOUT_CYCLES=16 with SCL held high (I2cMain stubbed).
  - ERR0 pulses at LAUNCH+16 cycles; DONE0 does not pulse; RDATA0 is unchanged; the next request is granted.
- Reset mid-transaction: RESET asserted during WAIT_STOP.
  - All outputs are 0 asynchronously; no DONE/ERR.
  - After release, REQ1 alone is granted normally.
- Data change after grant: WDATA0 is changed from 16'hBEEF to 16'h0000 two cycles after grant.
  - WR_DATA stays BEEF and the secondary WRS_DATA=BEEF.
